// File: rtl/shared_ll_fifo_pkg.sv
// Shared constants and helpers for the linked-list multi-queue FIFO.
// Widths stay module parameters; only width-independent conventions live here.
package shared_ll_fifo_pkg;

  // Pointer value used for empty head/tail registers; never dereferenced while count is 0.
  localparam int unsigned NullIdx = 0;

  function automatic logic op_legal(input logic req, input logic blocked);
    return req && !blocked;
  endfunction

  // Free list starts as 0 -> 1 -> ... -> DEPTH-1; the last link is a don't-care.
  function automatic int unsigned reset_next_idx(input int unsigned idx,
                                                 input int unsigned depth);
    return (idx + 1) % depth;
  endfunction

endpackage

// File: rtl/shared_ll_fifo_if.sv
// Push/pop/status bundle of shared_ll_fifo; master drives requests, slave is the FIFO.
interface shared_ll_fifo_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_FIFOS = 4
);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_FIFOS);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic                           push;
  logic [SEL_WIDTH-1:0]           push_sel;
  logic [WIDTH-1:0]               data_in;
  logic                           pop;
  logic [SEL_WIDTH-1:0]           pop_sel;
  logic [WIDTH-1:0]               data_out;
  logic [NUM_FIFOS-1:0]           empty;
  logic [NUM_FIFOS-1:0]           full;
  logic [NUM_FIFOS*CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0]           free_count;
  logic                           err;

  modport master (
    output push, push_sel, data_in, pop, pop_sel,
    input  data_out, empty, full, count, free_count, err
  );

  modport slave (
    input  push, push_sel, data_in, pop, pop_sel,
    output data_out, empty, full, count, free_count, err
  );
endinterface

// File: rtl/shared_ll_fifo_free_list.sv
// ll_free_list: head/tail/count of the unallocated-entry chain. The parent owns next[];
// this block reads next[free_head] via i_alloc_next and requests link writes via o_link_*.
module ll_free_list
  import shared_ll_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alloc,
  input  logic                 i_release,
  input  logic [PTR_WIDTH-1:0] i_release_ptr,
  input  logic [PTR_WIDTH-1:0] i_alloc_next,
  output logic [PTR_WIDTH-1:0] o_alloc_ptr,
  output logic [CNT_WIDTH-1:0] o_free_count,
  output logic                 o_link_we,
  output logic [PTR_WIDTH-1:0] o_link_ptr,
  output logic [PTR_WIDTH-1:0] o_link_val
);

  logic [PTR_WIDTH-1:0] r_free_head;
  logic [PTR_WIDTH-1:0] r_free_tail;
  logic [CNT_WIDTH-1:0] r_free_count;
  logic                 w_restart;

  // Released entry becomes the whole list when nothing else will remain on it.
  always_comb begin
    w_restart    = (r_free_count == '0) ||
                   (i_alloc && (r_free_count == CNT_WIDTH'(1)));
    o_link_we    = i_release && !w_restart;
    o_link_ptr   = r_free_tail;
    o_link_val   = i_release_ptr;
    o_alloc_ptr  = r_free_head;
    o_free_count = r_free_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free_head  <= PTR_WIDTH'(NullIdx);
      r_free_tail  <= PTR_WIDTH'(DEPTH - 1);
      r_free_count <= CNT_WIDTH'(DEPTH);
    end else begin
      if (i_alloc) r_free_head <= i_alloc_next;
      if (i_release) begin
        r_free_tail <= i_release_ptr;
        if (w_restart) r_free_head <= i_release_ptr;
      end
      r_free_count <= r_free_count + CNT_WIDTH'(i_release) - CNT_WIDTH'(i_alloc);
    end
  end

endmodule

// File: rtl/shared_ll_fifo.sv
// NUM_FIFOS linked-list queues sharing one DEPTH-entry RAM with a linked free list.
// Define SHARED_LL_FIFO_QUOTA_EN to cap each queue at QUOTA entries.
module shared_ll_fifo
  import shared_ll_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned QUOTA     = DEPTH / 2
) (
  input logic             clk,
  input logic             rst,
  shared_ll_fifo_if.slave bus
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned SEL_WIDTH = $clog2(NUM_FIFOS);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  if (QUOTA < 1 || QUOTA > DEPTH) begin : g_bad_quota
    $error("shared_ll_fifo: QUOTA must be within 1..DEPTH");
  end

  logic [WIDTH-1:0]     r_ram   [DEPTH];
  logic [PTR_WIDTH-1:0] r_next  [DEPTH];
  logic [PTR_WIDTH-1:0] r_head  [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] r_tail  [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] r_count [NUM_FIFOS];
  logic                 r_err;

  logic [NUM_FIFOS-1:0] w_empty;
  logic [NUM_FIFOS-1:0] w_full;
  logic [CNT_WIDTH-1:0] w_free_count;
  logic [PTR_WIDTH-1:0] w_alloc_ptr;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_push_to_empty;
  logic                 w_link_we;
  logic [PTR_WIDTH-1:0] w_link_ptr;
  logic [PTR_WIDTH-1:0] w_link_val;

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      w_empty[q] = (r_count[q] == '0);
`ifdef SHARED_LL_FIFO_QUOTA_EN
      w_full[q]  = (w_free_count == '0) || (r_count[q] == CNT_WIDTH'(QUOTA));
`else
      w_full[q]  = (w_free_count == '0);
`endif
    end
    w_push_ok = op_legal(bus.push, w_full[bus.push_sel]);
    w_pop_ok  = op_legal(bus.pop, w_empty[bus.pop_sel]);
    // A same-queue pop of the only entry leaves the pushed entry as the new head.
    w_push_to_empty = w_empty[bus.push_sel] ||
                      (w_pop_ok && (bus.pop_sel == bus.push_sel) &&
                       (r_count[bus.push_sel] == CNT_WIDTH'(1)));
  end

  ll_free_list #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_free_list (
    .clk           (clk),
    .rst           (rst),
    .i_alloc       (w_push_ok),
    .i_release     (w_pop_ok),
    .i_release_ptr (r_head[bus.pop_sel]),
    .i_alloc_next  (r_next[w_alloc_ptr]),
    .o_alloc_ptr   (w_alloc_ptr),
    .o_free_count  (w_free_count),
    .o_link_we     (w_link_we),
    .o_link_ptr    (w_link_ptr),
    .o_link_val    (w_link_val)
  );

  always_ff @(posedge clk) begin
    if (w_push_ok && !rst) r_ram[w_alloc_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_next[i] <= PTR_WIDTH'(reset_next_idx(i, DEPTH));
      end
      for (int q = 0; q < NUM_FIFOS; q++) begin
        r_head[q]  <= PTR_WIDTH'(NullIdx);
        r_tail[q]  <= PTR_WIDTH'(NullIdx);
        r_count[q] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      // Free-tail and queue-tail links never target the same entry.
      if (w_link_we) r_next[w_link_ptr] <= w_link_val;
      if (w_pop_ok) r_head[bus.pop_sel] <= r_next[r_head[bus.pop_sel]];
      if (w_push_ok) begin
        r_tail[bus.push_sel] <= w_alloc_ptr;
        if (w_push_to_empty) r_head[bus.push_sel] <= w_alloc_ptr;
        else                 r_next[r_tail[bus.push_sel]] <= w_alloc_ptr;
      end
      for (int q = 0; q < NUM_FIFOS; q++) begin
        r_count[q] <= r_count[q]
                    + CNT_WIDTH'(w_push_ok && (bus.push_sel == SEL_WIDTH'(q)))
                    - CNT_WIDTH'(w_pop_ok && (bus.pop_sel == SEL_WIDTH'(q)));
      end
      if ((bus.push && !w_push_ok) || (bus.pop && !w_pop_ok)) r_err <= 1'b1;
    end
  end

  always_comb begin
    bus.data_out   = r_ram[r_head[bus.pop_sel]];
    bus.empty      = w_empty;
    bus.full       = w_full;
    bus.free_count = w_free_count;
    bus.err        = r_err;
    bus.count      = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      bus.count[q*CNT_WIDTH +: CNT_WIDTH] = r_count[q];
    end
  end

endmodule

// File: tb/tb_shared_ll_fifo.sv
// Self-checking bench for shared_ll_fifo: directed steps plus random traffic against
// a queue-based reference model of the shared pool.
module tb_shared_ll_fifo;

  localparam int unsigned Width    = 8;
  localparam int unsigned Depth    = 8;
  localparam int unsigned NumFifos = 4;
  localparam int unsigned Quota    = Depth / 2;
  localparam int unsigned CntW     = 4;
`ifdef SHARED_LL_FIFO_QUOTA_EN
  localparam bit QuotaEn = 1'b1;
`else
  localparam bit QuotaEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  shared_ll_fifo_if #(.WIDTH(Width), .DEPTH(Depth), .NUM_FIFOS(NumFifos)) bus ();

  shared_ll_fifo #(
    .WIDTH     (Width),
    .DEPTH     (Depth),
    .NUM_FIFOS (NumFifos),
    .QUOTA     (Quota)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [Width-1:0] mq [NumFifos][$];
  int               mfree;
  bit               merr;

  function automatic bit m_full(int q);
    return (mfree == 0) || (QuotaEn && (mq[q].size() == Quota));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every output against the model; sweeps pop_sel to view each head.
  task automatic check_all(input string tag);
    for (int q = 0; q < NumFifos; q++) begin
      chk({tag, "_empty"}, 32'(bus.empty[q]), 32'(mq[q].size() == 0));
      chk({tag, "_full"}, 32'(bus.full[q]), 32'(m_full(q)));
      chk({tag, "_count"}, 32'(bus.count[q*CntW +: CntW]), 32'(mq[q].size()));
      bus.pop_sel = 2'(q);
      #1;
      if (mq[q].size() != 0) chk({tag, "_data"}, 32'(bus.data_out), 32'(mq[q][0]));
    end
    chk({tag, "_free"}, 32'(bus.free_count), 32'(mfree));
    chk({tag, "_err"}, 32'(bus.err), 32'(merr));
  endtask

  task automatic cycle(input bit p, input int ps, input logic [Width-1:0] d,
                       input bit o, input int os, input string tag);
    bit push_ok, pop_ok;
    push_ok = p && !m_full(ps);
    pop_ok  = o && (mq[os].size() != 0);
    bus.push = p; bus.push_sel = 2'(ps); bus.data_in = d;
    bus.pop  = o; bus.pop_sel  = 2'(os);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    if ((p && !push_ok) || (o && !pop_ok)) merr = 1'b1;
    if (pop_ok) begin
      void'(mq[os].pop_front());
      mfree++;
    end
    if (push_ok) begin
      mq[ps].push_back(d);
      mfree--;
    end
    check_all(tag);
  endtask

  task automatic do_reset(input bit with_ops, input string tag);
    rst = 1'b1;
    bus.push = with_ops; bus.push_sel = 2'd0; bus.data_in = 8'h5A;
    bus.pop  = with_ops; bus.pop_sel  = 2'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    for (int q = 0; q < NumFifos; q++) mq[q].delete();
    mfree = Depth;
    merr  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.push = 1'b0; bus.push_sel = '0; bus.data_in = '0;
    bus.pop  = 1'b0; bus.pop_sel  = '0;
    mfree = Depth;
    merr  = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0, "reset");
    chk("reset_free_const", 32'(bus.free_count), 32'd8);
    chk("reset_empty_const", 32'(bus.empty), 32'hF);

`ifndef SHARED_LL_FIFO_QUOTA_EN
    for (int i = 0; i < 8; i++) cycle(1'b1, 0, 8'(8'h10 + i), 1'b0, 0, "fill_q0");
    chk("fill_free_zero", 32'(bus.free_count), 32'd0);
    chk("fill_full_all", 32'(bus.full), 32'hF);
    for (int i = 0; i < 8; i++) begin
      bus.pop_sel = 2'd0;
      #1;
      chk("drain_data", 32'(bus.data_out), 32'(8'h10 + i));
      cycle(1'b0, 0, 8'h00, 1'b1, 0, "drain_q0");
    end
    chk("drain_err", 32'(bus.err), 32'd0);
`endif

    // Interleaved pushes, then drain queue 2 only.
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < NumFifos; q++) begin
        cycle(1'b1, q, 8'(8'h40 + 16 * q + r), 1'b0, 0, "ilv_push");
      end
    end
    bus.pop_sel = 2'd2;
    #1;
    chk("ilv_q2_head", 32'(bus.data_out), 32'h60);
    cycle(1'b0, 0, 8'h00, 1'b1, 2, "ilv_pop2");
    cycle(1'b0, 0, 8'h00, 1'b1, 2, "ilv_pop2");

    // Same-queue push and pop with a single entry resident.
    do_reset(1'b0, "reset2");
    cycle(1'b1, 1, 8'hAA, 1'b0, 0, "same_pre");
    cycle(1'b1, 1, 8'hBB, 1'b1, 1, "same_pp");
    bus.pop_sel = 2'd1;
    #1;
    chk("same_data_const", 32'(bus.data_out), 32'hBB);
    chk("same_count_const", 32'(bus.count[1*CntW +: CntW]), 32'd1);

    // Full boundary: push rejected while a pop frees an entry.
    do_reset(1'b0, "reset3");
    for (int i = 0; i < 8; i++) cycle(1'b1, i % 4, 8'(8'h80 + i), 1'b0, 0, "bnd_fill");
    cycle(1'b1, 3, 8'hEE, 1'b1, 0, "bnd_pp");
    chk("bnd_err_const", 32'(bus.err), 32'd1);
    chk("bnd_free_const", 32'(bus.free_count), 32'd1);

`ifdef SHARED_LL_FIFO_QUOTA_EN
    do_reset(1'b0, "reset_q");
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 8'(8'hC0 + i), 1'b0, 0, "quota_fill");
    chk("quota_full0", 32'(bus.full[0]), 32'd1);
    chk("quota_full1", 32'(bus.full[1]), 32'd0);
    cycle(1'b1, 0, 8'hCF, 1'b0, 0, "quota_over");
    chk("quota_err", 32'(bus.err), 32'd1);
    chk("quota_count", 32'(bus.count[0 +: CntW]), 32'd4);
`endif

    // Reset mid-operation, with push and pop asserted in the reset cycle.
    do_reset(1'b0, "reset4");
    for (int i = 0; i < 5; i++) cycle(1'b1, i % 3, 8'(8'h30 + i), 1'b0, 0, "mid_fill");
    do_reset(1'b1, "mid_reset");
    chk("mid_free_const", 32'(bus.free_count), 32'd8);

    // Random traffic, pushes biased slightly so the pool fills and drains.
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset($urandom_range(0, 1) == 1, "rand_reset");
      else cycle($urandom_range(0, 9) < 6, int'($urandom_range(0, NumFifos - 1)),
                 8'($urandom), $urandom_range(0, 9) < 5,
                 int'($urandom_range(0, NumFifos - 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_ll_fifo.md
# shared_ll_fifo

Parametrised successor to `linked_list_fifo`. It holds NUM_FIFOS logical FIFOs in one shared DEPTH-entry data RAM, with per-entry next-pointer links and a linked free list. Over its predecessor it adds:
- a push and a pop in the same cycle, to any queues, including the same queue;
- per-queue occupancy counts;
- a sticky error flag for illegal operations;
- an optional per-queue quota.

It sits between arbitrated producers and consumers wherever several queues share one storage pool. Its behaviour is checked against one `shift_register_fifo` per queue.

## Interface
Parameters:
- WIDTH, 8, data bits per entry
- DEPTH, 8, shared entries (power of two, ≥2)
- NUM_FIFOS, 4, logical queues (≥2)
- QUOTA, DEPTH/2, max entries per queue (used only with SHARED_LL_FIFO_QUOTA_EN; 1..DEPTH)
- PTR_WIDTH, $clog2(DEPTH), derived
- SEL_WIDTH, $clog2(NUM_FIFOS), derived
- CNT_WIDTH, $clog2(DEPTH+1), derived

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  enqueue data_in to queue push_sel
- push_sel  in  SEL_WIDTH  target queue for push
- data_in  in  WIDTH  push data
- pop  in  1  dequeue head of queue pop_sel
- pop_sel  in  SEL_WIDTH  target queue for pop; also selects data_out
- data_out  out  WIDTH  head entry of queue pop_sel (show-ahead)
- empty  out  NUM_FIFOS  per-queue empty
- full  out  NUM_FIFOS  per-queue "push would be rejected"
- count  out  NUM_FIFOS*CNT_WIDTH  per-queue occupancy, queue i at [i*CNT_WIDTH +: CNT_WIDTH]
- free_count  out  CNT_WIDTH  unallocated entries
- err  out  1  sticky illegal-operation flag

## Operation
- **State:**
  - data RAM[DEPTH];
  - next[DEPTH] pointer array;
  - per-queue head, tail, count;
  - free_head, free_tail, free_count;
  - err.
- **Reset:**
  - every count is 0;
  - free list chains 0→1→…→DEPTH-1, so free_head=0, free_tail=DEPTH-1 and free_count=DEPTH;
  - err=0.
- **Output values out of reset:** empty all 1, full all 0, data_out = RAM[head[pop_sel]] (don't-care while empty).
- **Legal push:** `push && !full[push_sel]`.
  - Write data_in to RAM[free_head].
  - Append that entry to queue push_sel: if the queue was empty, head = entry; otherwise next[tail] = entry. In both cases tail = entry.
  - free_head advances to next[free_head].
- **Legal pop:** `pop && !empty[pop_sel]`.
  - head[pop_sel] advances to next[head].
  - The freed entry is appended to the free tail.
- **Legality is judged on pre-edge state only.**
  - Push to a queue that is full and being popped in the same cycle: rejected.
  - Pop of a queue that is empty and being pushed in the same cycle: rejected.
- **Illegal operation:** the operation is ignored with no state change for it, and err sets. Only rst clears err. A legal operation issued in the same cycle still executes.
- **Simultaneous legal push and pop:**
  - Same queue, count==1: head and tail both become the pushed entry.
  - Any queues, free_count==1: the pushed entry takes free_head, and the free list becomes exactly the popped entry (head = tail = popped entry).
- **Count updates:** count[q] changes by +push_q − pop_q. free_count changes by −push + pop.
- **Invariant:** free_count plus the sum of all count[q] equals DEPTH.
- **full[q]:**
  - Base: free_count==0.
  - With quota enabled: also true when count[q]==QUOTA.
- **empty[q]:** count[q]==0.

## Timing
- data_out is combinational from pop_sel and the registered state. It shows the head of the selected queue with no latency.
- A pushed entry is visible on data_out and count the cycle after the push edge.
- A pop takes effect at the edge; the next head appears in the following cycle.
- All outputs except data_out come directly from registers or simple compares of registers.
- Reset asserted mid-operation discards all queue contents in one cycle. Push or pop in a reset cycle is ignored and does not set err.

## Configuration
- **SHARED_LL_FIFO_QUOTA_EN defined:**
  - full[q] also asserts when count[q]==QUOTA;
  - a push beyond the quota is illegal and sets err.
  - No queue can starve the others of entries.
- **Undefined:** QUOTA is ignored, every full bit equals (free_count==0), and quota comparators are absent.

## Structure
- **Package `shared_ll_fifo_pkg`:** the legality-check function and reset free-chain helper, and shared constants such as the NULL pointer convention.
  - Widths stay parameters, not package typedefs.
- **Sub-module `ll_free_list`:** owns free_head, free_tail, free_count and their reset chain.
  - Inputs: alloc, release, release_ptr.
  - Outputs: alloc_ptr, free_count.
  - The parent owns the next[] array and passes the free-list link write-back through the sub-module interface.

## Test plan
- **Reset contents:** reset, then 8 pushes to queue 0 (DEPTH=8, no quota) with data 0x10..0x17 → free_count 0, full all 1, pops return 0x10..0x17 in order, err=0.
- **Interleaving:** alternate pushes to queues 0–3, then pop queue 2 → only queue 2's data appears, in FIFO order; the other counts are unchanged.
- **Same-cycle push/pop, same queue:** queue 1 holds one entry (0xAA); push 0xBB and pop queue 1 together → next cycle count[1]=1, data_out=0xBB, err=0.
- **Full boundary:** free_count 0; push queue 3 together with pop queue 0 → push rejected, err=1, free_count=1 next cycle.
- **Quota (SHARED_LL_FIFO_QUOTA_EN, QUOTA=4):** 4 pushes to queue 0 → full[0]=1, full[1]=0; a 5th push sets err, and count[0] stays 4.
- **Reset mid-operation:** with 5 entries spread across queues, assert rst for one cycle alongside push → all empty, free_count=8, err=0.
